// File: rtl/pc_gen.sv
// Program-counter generation stage feeding fetch: start/enable, stalls, redirects, halt.
// Optional PC_BOUNDS_EN halts with a sticky fault when the next PC exceeds IMEM_DEPTH-1.
module pc_gen #(
    parameter int unsigned       ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int unsigned       IMEM_DEPTH = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    input  logic              halt_req,
    output logic [ADDR_W-1:0] pc,
    output logic              pc_valid,
    output logic              flush,
    output logic              halted,
    output logic              fault,
    output logic [31:0]       fetch_count
);

`ifdef PC_BOUNDS_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    localparam logic [ADDR_W:0] PC_MAX = (ADDR_W+1)'(IMEM_DEPTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StStall, StHalt} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic              valid_q;
    logic              flush_q;
    logic              halted_q;
    logic              fault_q;
    logic              pend_q;
    logic [ADDR_W-1:0] pend_tgt_q;
    logic [31:0]       count_q;

    logic [ADDR_W:0]   inc_wide;
    logic [ADDR_W-1:0] rel_tgt;
    logic              rel_jump;

    // Checked one bit wider than the PC so a wrap at 2^ADDR_W still counts as out of range.
    function automatic logic out_of_range(input logic [ADDR_W:0] t);
        return BOUNDS_EN && (t > PC_MAX);
    endfunction

    assign inc_wide = {1'b0, pc_q} + {{ADDR_W{1'b0}}, 1'b1};
    // On stall release a same-cycle redirect beats the pending entry.
    assign rel_tgt  = redirect_valid ? redirect_target : pend_tgt_q;
    assign rel_jump = redirect_valid | pend_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            flush_q    <= 1'b0;
            halted_q   <= 1'b0;
            fault_q    <= 1'b0;
            pend_q     <= 1'b0;
            pend_tgt_q <= '0;
            count_q    <= '0;
        end else begin
            flush_q <= 1'b0;
            if (valid_q) count_q <= count_q + 32'd1;
            if (state_q != StHalt && halt_req) begin
                state_q  <= StHalt;
                valid_q  <= 1'b0;
                halted_q <= 1'b1;
                pend_q   <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (enable) begin
                            if (stall) begin
                                state_q <= StStall;
                            end else begin
                                state_q <= StRun;
                                valid_q <= 1'b1;
                            end
                        end
                    end
                    StRun: begin
                        if (redirect_valid) begin
                            if (out_of_range({1'b0, redirect_target})) begin
                                state_q  <= StHalt;
                                valid_q  <= 1'b0;
                                halted_q <= 1'b1;
                                fault_q  <= 1'b1;
                            end else begin
                                pc_q    <= redirect_target;
                                flush_q <= 1'b1;
                            end
                        end else if (stall) begin
                            state_q <= StStall;
                            valid_q <= 1'b0;
                        end else if (!enable) begin
                            state_q <= StIdle;
                            valid_q <= 1'b0;
                        end else if (out_of_range(inc_wide)) begin
                            state_q  <= StHalt;
                            valid_q  <= 1'b0;
                            halted_q <= 1'b1;
                            fault_q  <= 1'b1;
                        end else begin
                            pc_q <= inc_wide[ADDR_W-1:0];
                        end
                    end
                    StStall: begin
                        if (stall) begin
                            if (redirect_valid) begin
                                pend_q     <= 1'b1;
                                pend_tgt_q <= redirect_target;
                            end
                        end else begin
                            pend_q <= 1'b0;
                            if (rel_jump && out_of_range({1'b0, rel_tgt})) begin
                                state_q  <= StHalt;
                                halted_q <= 1'b1;
                                fault_q  <= 1'b1;
                            end else begin
                                state_q <= StRun;
                                valid_q <= 1'b1;
                                if (rel_jump) begin
                                    pc_q    <= rel_tgt;
                                    flush_q <= 1'b1;
                                end
                            end
                        end
                    end
                    StHalt: begin
                    end
                endcase
            end
        end
    end

    assign pc          = pc_q;
    assign pc_valid    = valid_q;
    assign flush       = flush_q;
    assign halted      = halted_q;
    assign fault       = fault_q;
    assign fetch_count = count_q;

endmodule
